i2s_frame_timer: RTL and testbench

//  Generates the I2S bit clock, word-select clock and start level that drive the
//  SoC's I2S serializer (i2s_sclk / i2s_lrclk / i2s_start inputs). It also

---
 rtl/i2s_frame_timer.sv | 202 ++++++++++++++++++++
 tb/tb_i2s_frame_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_timer.sv
// ---------------------------------------------------------------------------
// i2s_frame_timer
//
// Purpose:
//   Generates the I2S bit clock (i2s_sclk), word select (i2s_lrclk) and the
//   serializer start level (i2s_start) for the SoC's I2S block. It also
//   deserializes the SoC's serial output back into parallel left/right samples
//   for the level-meter and loopback paths. Everything runs in the single
//   system clock domain (Clk).
//
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous, active-high reset
//   enable        in   1 = run; 0 = stop at the next frame boundary
//   i2s_data_in   in   serial data from the SoC (I2S format, MSB first)
//   i2s_sclk      out  bit clock, Clk/(2*SCLK_HALF_DIV)
//   i2s_lrclk     out  word select: 0 = left slot, 1 = right slot
//   i2s_start     out  high only while in RUN
//   left_sample   out  last complete left sample
//   right_sample  out  last complete right sample
//   sample_valid  out  one-Clk pulse when the left/right pair updates
//   running       out  high in SYNC, RUN and DRAIN
//   o_dbg_state   out  current FSM state (IDLE=0, SYNC=1, RUN=2, DRAIN=3)
//
// sample_valid is a pure pulse with no back-pressure: the consumer must take
// left_sample/right_sample in the cycle sample_valid is high (they then hold
// until the next pulse).
// ---------------------------------------------------------------------------
module i2s_frame_timer #(
    parameter int SCLK_HALF_DIV = 8,
    parameter int BITS_PER_CH   = 32,
    parameter int SAMPLE_W      = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                enable,
    input  logic                i2s_data_in,
    output logic                i2s_sclk,
    output logic                i2s_lrclk,
    output logic                i2s_start,
    output logic [SAMPLE_W-1:0] left_sample,
    output logic [SAMPLE_W-1:0] right_sample,
    output logic                sample_valid,
    output logic                running,
    output logic [1:0]          o_dbg_state
);

    localparam int DIV_W = $clog2(SCLK_HALF_DIV);
    localparam int BIT_W = $clog2(2 * BITS_PER_CH);
    localparam int SH_W  = (SAMPLE_W > 1) ? SAMPLE_W - 1 : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(2 * BITS_PER_CH - 1);
    localparam logic [BIT_W-1:0] CH_BITS = BIT_W'(BITS_PER_CH);
    localparam logic [BIT_W-1:0] LAST_SB = BIT_W'(SAMPLE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DIV_W-1:0]    r_div_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_sclk;
    logic                r_lrclk;
    logic [SH_W-1:0]     r_shift;
    logic [SAMPLE_W-1:0] r_left_hold;
    logic [SAMPLE_W-1:0] r_right_hold;
    logic                r_left_seen;
    logic                r_pend;
    logic [SAMPLE_W-1:0] r_left_out;
    logic [SAMPLE_W-1:0] r_right_out;
    logic                r_valid;

    logic                w_active;
    logic                w_div_wrap;
    logic                w_fall;
    logic                w_rise;
    logic                w_frame_wrap;
    logic                w_capture;
    logic [BIT_W-1:0]    w_bit_next;
    logic [BIT_W-1:0]    w_slot_bit;
    logic                w_in_sample;
    logic [SAMPLE_W-1:0] w_shift_next;

    assign w_active     = (r_state != ST_IDLE);
    assign w_div_wrap   = w_active && (r_div_cnt == DIV_MAX);
    // sclk toggles on every divider wrap; the current level tells which edge it is.
    assign w_fall       = w_div_wrap && r_sclk;
    assign w_rise       = w_div_wrap && !r_sclk;
    assign w_frame_wrap = w_fall && (r_bit_cnt == BIT_MAX);
    assign w_capture    = w_rise && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_bit_next   = (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + 1'b1;

    // Position inside the current channel slot; slot bit 0 is the I2S delay bit.
    assign w_slot_bit   = (r_bit_cnt >= CH_BITS) ? r_bit_cnt - CH_BITS : r_bit_cnt;
    assign w_in_sample  = (w_slot_bit != '0) && (w_slot_bit <= LAST_SB);

    generate
        if (SAMPLE_W > 1) begin : g_shift_multi
            assign w_shift_next = {r_shift, i2s_data_in};
        end else begin : g_shift_single
            assign w_shift_next = i2s_data_in;
        end
    endgenerate

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; SYNC and DRAIN only leave at the frame boundary.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (enable)       w_state_next = ST_SYNC;
            ST_SYNC:  if (w_frame_wrap) w_state_next = enable ? ST_RUN : ST_IDLE;
            ST_RUN:   if (!enable)      w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_frame_wrap) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Clock generation, capture and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_lrclk      <= 1'b0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_left_seen  <= 1'b0;
            r_pend       <= 1'b0;
            r_left_out   <= '0;
            r_right_out  <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_pend  <= 1'b0;
            r_valid <= r_pend;
            if (r_pend) begin
                r_left_out  <= r_left_hold;
                r_right_out <= r_right_hold;
            end

            if (!w_active) begin
                // Idle: clocks parked low, and a new run must see a fresh left word
                // before it can publish a pair.
                r_div_cnt   <= '0;
                r_bit_cnt   <= '0;
                r_sclk      <= 1'b0;
                r_lrclk     <= 1'b0;
                r_left_seen <= 1'b0;
            end else begin
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
                if (w_div_wrap) begin
                    r_sclk <= ~r_sclk;
                end
                // The frame-wrap fall lands bit_cnt and lrclk at 0, so leaving
                // for IDLE parks both clocks low on the same edge.
                if (w_fall) begin
                    r_bit_cnt <= w_bit_next;
                    r_lrclk   <= (w_bit_next >= CH_BITS);
                end
                if (w_capture && w_in_sample) begin
                    r_shift <= w_shift_next[SH_W-1:0];
                    if (w_slot_bit == LAST_SB) begin
                        if (r_lrclk) begin
                            r_right_hold <= w_shift_next;
                            if (r_left_seen) begin
                                r_pend <= 1'b1;
                            end
                        end else begin
                            r_left_hold <= w_shift_next;
                            r_left_seen <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign i2s_sclk     = r_sclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_start    = (r_state == ST_RUN);
    assign running      = w_active;
    assign left_sample  = r_left_out;
    assign right_sample = r_right_out;
    assign sample_valid = r_valid;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_i2s_frame_timer.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_timer
//
// Bench for i2s_frame_timer at default parameters. A small I2S transmitter
// slaved to the DUT's sclk/lrclk drives i2s_data_in; the expected sample pair
// for each frame is queued when its data is set up and popped on sample_valid.
// ---------------------------------------------------------------------------
module tb_i2s_frame_timer;

    localparam int SW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          enable = 1'b0;
    logic          i2s_data_in;
    logic          i2s_sclk;
    logic          i2s_lrclk;
    logic          i2s_start;
    logic [SW-1:0] left_sample;
    logic [SW-1:0] right_sample;
    logic          sample_valid;
    logic          running;
    logic [1:0]    o_dbg_state;

    always #5 Clk = ~Clk;

    i2s_frame_timer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .enable       (enable),
        .i2s_data_in  (i2s_data_in),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_start    (i2s_start),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .running      (running),
        .o_dbg_state  (o_dbg_state)
    );

    int            n_total = 0;
    int            n_bad = 0;
    logic [31:0]   exp_q[$];
    logic [SW-1:0] tx_left = '0;
    logic [SW-1:0] tx_right = '0;
    int            tx_mode = 0;   // 0 = I2S words, 1 = constant 1, 2 = constant 0
    int            epoch = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transmitter + scoreboard, sampled 1 time unit after each rising edge.
    logic          prev_sclk = 1'b0;
    logic          prev_lrclk = 1'b0;
    logic          prev_valid = 1'b0;
    logic [SW-1:0] tx_word;
    logic [31:0]   exp_pair;
    int            pos = 0;
    int            cyc = 0;
    int            last_pulse = -1;
    int            seen_epoch = 0;

    always @(posedge Clk) begin
        #1;
        cyc++;
        if (!running) begin
            pos = 0;
        end else if (prev_sclk && !i2s_sclk) begin
            if (i2s_lrclk != prev_lrclk) pos = 0;
            else pos++;
        end
        if (tx_mode == 1) begin
            i2s_data_in = 1'b1;
        end else if (tx_mode == 2) begin
            i2s_data_in = 1'b0;
        end else if (pos >= 1 && pos <= SW) begin
            tx_word = i2s_lrclk ? tx_right : tx_left;
            i2s_data_in = tx_word[SW - pos];
        end else begin
            i2s_data_in = 1'b0;
        end
        prev_sclk  = i2s_sclk;
        prev_lrclk = i2s_lrclk;

        if (seen_epoch != epoch) begin
            last_pulse = -1;
            seen_epoch = epoch;
        end
        if (sample_valid) begin
            check("valid_width", prev_valid, 1'b0);
            if (last_pulse >= 0) check("valid_gap", cyc - last_pulse, 1024);
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", sample_valid, 1'b0);
            end else begin
                exp_pair = exp_q.pop_front();
                check("left_sample", left_sample, exp_pair[31:16]);
                check("right_sample", right_sample, exp_pair[15:0]);
            end
        end
        prev_valid = sample_valid;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_sclk"}, i2s_sclk, 0);
        check({tag, "_lrclk"}, i2s_lrclk, 0);
        check({tag, "_start"}, i2s_start, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_left"}, left_sample, 0);
        check({tag, "_right"}, right_sample, 0);
        check({tag, "_state"}, o_dbg_state, 0);
    endtask

    initial begin
        i2s_data_in = 1'b0;
        Reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");

        // Continuous run: SYNC timing, data frames, all-ones/all-zeros, drain.
        Reset    = 1'b0;
        tx_left  = 16'hA5C3;
        tx_right = 16'h3C5A;
        tx_mode  = 0;
        repeat (3) exp_q.push_back({16'hA5C3, 16'h3C5A});
        epoch++;
        enable = 1'b1;
        @(negedge Clk);
        for (int c = 0; c <= 9300; c++) begin
            if (c <= 1100) begin
                check("sync_sclk", i2s_sclk, (c / 8) % 2);
                check("sync_lrclk", i2s_lrclk, ((c / 16) % 64) >= 32);
                check("sync_start", i2s_start, c >= 1024);
                check("sync_running", running, 1);
            end
            case (c)
                0:    check("state_sync", o_dbg_state, 1);
                1024: check("state_run", o_dbg_state, 2);
                4096: begin
                    tx_mode = 1;
                    repeat (2) exp_q.push_back({16'hFFFF, 16'hFFFF});
                end
                6144: begin
                    tx_mode = 2;
                    exp_q.push_back({16'h0000, 16'h0000});
                end
                7168: begin
                    tx_mode  = 0;
                    tx_left  = 16'h1234;
                    tx_right = 16'hABCD;
                    exp_q.push_back({16'h1234, 16'hABCD});
                end
                7268: enable = 1'b0;
                7300: begin
                    check("drain_start", i2s_start, 0);
                    check("drain_running", running, 1);
                    check("state_drain", o_dbg_state, 3);
                end
                8191: begin
                    check("drain_end_running", running, 1);
                    check("drain_end_sclk", i2s_sclk, 1);
                    check("drain_end_lrclk", i2s_lrclk, 1);
                end
                8192: begin
                    check("stop_running", running, 0);
                    check("stop_sclk", i2s_sclk, 0);
                    check("stop_lrclk", i2s_lrclk, 0);
                    check("stop_start", i2s_start, 0);
                    check("state_idle", o_dbg_state, 0);
                end
                9300: check("idle_running", running, 0);
                default: ;
            endcase
            @(negedge Clk);
        end
        check("queue_after_drain", exp_q.size(), 0);

        // Short enable pulse in IDLE: exactly one SYNC frame, never RUN.
        epoch++;
        enable = 1'b1;
        @(negedge Clk);
        for (int c = 0; c <= 1100; c++) begin
            if (c == 2) enable = 1'b0;
            check("pulse_start", i2s_start, 0);
            case (c)
                0:    check("pulse_state_sync", o_dbg_state, 1);
                1023: check("pulse_running_end", running, 1);
                1024: begin
                    check("pulse_running_off", running, 0);
                    check("pulse_sclk_off", i2s_sclk, 0);
                    check("pulse_lrclk_off", i2s_lrclk, 0);
                    check("pulse_state_idle", o_dbg_state, 0);
                end
                default: ;
            endcase
            @(negedge Clk);
        end

        // Reset mid-RUN, just after the right latch of the second RUN frame.
        tx_left  = 16'h0F0F;
        tx_right = 16'hF0F0;
        exp_q.push_back({16'h0F0F, 16'hF0F0});
        epoch++;
        enable = 1'b1;
        @(negedge Clk);
        for (int c = 0; c < 2824; c++) begin
            if (c == 1024) check("rst_run_state", o_dbg_state, 2);
            @(negedge Clk);
        end
        check("rst_first_pair_seen", exp_q.size(), 0);
        check("rst_pre_running", running, 1);
        Reset  = 1'b1;
        enable = 1'b0;
        @(negedge Clk);
        check_all_zero("midrun_reset");
        Reset = 1'b0;
        repeat (1100) @(negedge Clk);
        check("post_reset_running", running, 0);
        check("post_reset_valid", sample_valid, 0);

        check("queue_final", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
